// File: rtl/fp_adder_sequencer.sv
// Purpose: serialises four masked operand lanes plus an 8-bit setup word into a bit-serial adder, then reads its result back.
// Latency: 2*WIDTH+READ_LAT+2 cycles from acceptance to result_valid when output_rdy_in is already high in WAIT.
// Backpressure: req_ready only in IDLE; the result is held in DONE until result_ready; WAIT aborts after TIMEOUT cycles.
module fp_adder_sequencer #(
   parameter int WIDTH    = 16,
   parameter int TIMEOUT  = 64,
   parameter int READ_LAT = 1
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [WIDTH-1:0] op_c,
   input  logic [WIDTH-1:0] op_d,
   input  logic [2:0]       sub_op,
   input  logic [3:0]       lane_en,
   output logic             serial1_out,
   output logic             serial2_out,
   output logic             serial3_out,
   output logic             serial4_out,
   output logic             setup_serial_out,
   output logic             wr_out,
   input  logic             output_rdy_in,
   output logic             output_read_out,
   input  logic             serial_in,
   output logic             result_valid,
   input  logic             result_ready,
   output logic [WIDTH-1:0] result_data,
   output logic             result_err,
   output logic             busy
);

   localparam int CW = 5;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [CW-1:0] LOAD_LAST  = CW'(WIDTH - 1);
   localparam logic [CW-1:0] READ_LAST  = CW'(WIDTH + READ_LAT - 1);
   localparam logic [CW-1:0] STROBE_END = CW'(WIDTH);
   localparam logic [CW-1:0] LAT_START  = CW'(READ_LAT);
   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WAIT,
      ST_READ,
      ST_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
   // Lane shift registers are loaded already masked by lane_en, so a
   // disabled lane naturally shifts out zeros for the whole LOAD.
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] c_sh_q, c_sh_d;
   logic [WIDTH-1:0] d_sh_q, d_sh_d;
   // Setup word sits in the low 8 bits so zeros go out first and the
   // adder's setup register ends up holding exactly the last 8 bits.
   logic [WIDTH-1:0] setup_sh_q, setup_sh_d;
   logic [WIDTH-1:0] result_data_q, result_data_d;
   logic             result_err_q, result_err_d;
   logic [7:0]       setup_word;

   // Bit 0 clear selects the adder's internal clock.
   assign setup_word = {sub_op, lane_en[3], lane_en[2], lane_en[1], lane_en[0], 1'b0};

   // Next-state, counter and datapath update for the sequencer FSM.
   always_comb begin
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      tmo_cnt_d     = tmo_cnt_q;
      a_sh_d        = a_sh_q;
      b_sh_d        = b_sh_q;
      c_sh_d        = c_sh_q;
      d_sh_d        = d_sh_q;
      setup_sh_d    = setup_sh_q;
      result_data_d = result_data_q;
      result_err_d  = result_err_q;
      unique case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               a_sh_d        = {WIDTH{lane_en[3]}} & op_a;
               b_sh_d        = {WIDTH{lane_en[2]}} & op_b;
               c_sh_d        = {WIDTH{lane_en[1]}} & op_c;
               d_sh_d        = {WIDTH{lane_en[0]}} & op_d;
               setup_sh_d    = WIDTH'(setup_word);
               result_err_d  = 1'b0;
               result_data_d = '0;
               bit_cnt_d     = '0;
               state_d       = ST_LOAD;
            end
         end
         ST_LOAD: begin
            a_sh_d     = {a_sh_q[WIDTH-2:0], 1'b0};
            b_sh_d     = {b_sh_q[WIDTH-2:0], 1'b0};
            c_sh_d     = {c_sh_q[WIDTH-2:0], 1'b0};
            d_sh_d     = {d_sh_q[WIDTH-2:0], 1'b0};
            setup_sh_d = {setup_sh_q[WIDTH-2:0], 1'b0};
            if (bit_cnt_q == LOAD_LAST) begin
               bit_cnt_d = '0;
               tmo_cnt_d = '0;
               state_d   = ST_WAIT;
            end else begin
               bit_cnt_d = bit_cnt_q + CW'(1);
            end
         end
         ST_WAIT: begin
            // A ready seen on the last allowed cycle still wins over the abort.
            if (output_rdy_in) begin
               bit_cnt_d = '0;
               state_d   = ST_READ;
            end else if (tmo_cnt_q == TMO_LAST) begin
               result_err_d  = 1'b1;
               result_data_d = '0;
               state_d       = ST_DONE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TW'(1);
            end
         end
         ST_READ: begin
            // The adder's first bit appears READ_LAT cycles after the first strobe.
            if (bit_cnt_q >= LAT_START) begin
               result_data_d = {result_data_q[WIDTH-2:0], serial_in};
            end
            if (bit_cnt_q == READ_LAST) begin
               bit_cnt_d = '0;
               state_d   = ST_DONE;
            end else begin
               bit_cnt_d = bit_cnt_q + CW'(1);
            end
         end
         ST_DONE: begin
            if (result_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q       <= ST_IDLE;
         bit_cnt_q     <= '0;
         tmo_cnt_q     <= '0;
         a_sh_q        <= '0;
         b_sh_q        <= '0;
         c_sh_q        <= '0;
         d_sh_q        <= '0;
         setup_sh_q    <= '0;
         result_data_q <= '0;
         result_err_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         tmo_cnt_q     <= tmo_cnt_d;
         a_sh_q        <= a_sh_d;
         b_sh_q        <= b_sh_d;
         c_sh_q        <= c_sh_d;
         d_sh_q        <= d_sh_d;
         setup_sh_q    <= setup_sh_d;
         result_data_q <= result_data_d;
         result_err_q  <= result_err_d;
      end
   end

   // Strobes and serial lanes decode from state so they drop the cycle after any reset.
   always_comb begin
      req_ready        = (state_q == ST_IDLE);
      busy             = (state_q != ST_IDLE);
      wr_out           = (state_q == ST_LOAD);
      serial4_out      = wr_out & a_sh_q[WIDTH-1];
      serial3_out      = wr_out & b_sh_q[WIDTH-1];
      serial2_out      = wr_out & c_sh_q[WIDTH-1];
      serial1_out      = wr_out & d_sh_q[WIDTH-1];
      setup_serial_out = wr_out & setup_sh_q[WIDTH-1];
      output_read_out  = (state_q == ST_READ) && (bit_cnt_q < STROBE_END);
      result_valid     = (state_q == ST_DONE);
      result_data      = result_data_q;
      result_err       = result_err_q;
   end

endmodule

// File: tb/tb_fp_adder_sequencer.sv
// Bench for fp_adder_sequencer: directed transactions against a small serial adder responder.
// Outputs are sampled and inputs driven on the falling edge of clk_in.
// Every wait on the DUT is bounded by a cycle budget plus a global watchdog.
module tb_fp_adder_sequencer;

   localparam int WIDTH = 16;

   logic             clk_in;
   logic             rst_in;
   logic             req_valid;
   logic             req_ready;
   logic [WIDTH-1:0] op_a, op_b, op_c, op_d;
   logic [2:0]       sub_op;
   logic [3:0]       lane_en;
   logic             serial1_out, serial2_out, serial3_out, serial4_out;
   logic             setup_serial_out;
   logic             wr_out;
   logic             output_rdy_in;
   logic             output_read_out;
   logic             serial_in;
   logic             result_valid;
   logic             result_ready;
   logic [WIDTH-1:0] result_data;
   logic             result_err;
   logic             busy;

   int               n_checks = 0;
   int               n_errors = 0;
   logic [WIDTH-1:0] model_res = '0;
   int               rd_seen  = 0;

   fp_adder_sequencer #(.WIDTH(WIDTH), .TIMEOUT(64), .READ_LAT(1)) dut (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .op_a             (op_a),
      .op_b             (op_b),
      .op_c             (op_c),
      .op_d             (op_d),
      .sub_op           (sub_op),
      .lane_en          (lane_en),
      .serial1_out      (serial1_out),
      .serial2_out      (serial2_out),
      .serial3_out      (serial3_out),
      .serial4_out      (serial4_out),
      .setup_serial_out (setup_serial_out),
      .wr_out           (wr_out),
      .output_rdy_in    (output_rdy_in),
      .output_read_out  (output_read_out),
      .serial_in        (serial_in),
      .result_valid     (result_valid),
      .result_ready     (result_ready),
      .result_data      (result_data),
      .result_err       (result_err),
      .busy             (busy)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // Adder model: result bits appear MSB first, one cycle after each read strobe.
   always @(negedge clk_in) begin
      if (wr_out === 1'b1) rd_seen = 0;
      if (rd_seen >= 1 && rd_seen <= WIDTH) serial_in = model_res[WIDTH - rd_seen];
      else serial_in = 1'b0;
      if (output_read_out === 1'b1) rd_seen = rd_seen + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk_in);
   endtask

   // Runs one request from IDLE to DONE; collects the serial streams, cycle
   // latency from the acceptance cycle, strobe misuse and read strobe count.
   task automatic do_txn(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                         input logic [15:0] d, input logic [2:0] sub, input logic [3:0] en,
                         input int rdy_at, output int lat,
                         output logic [15:0] w4, output logic [15:0] w3, output logic [15:0] w2,
                         output logic [15:0] w1, output logic [15:0] su,
                         output int wr_bad, output int rd_cnt);
      lat = 0; wr_bad = 0; rd_cnt = 0;
      w4 = '0; w3 = '0; w2 = '0; w1 = '0; su = '0;
      op_a = a; op_b = b; op_c = c; op_d = d; sub_op = sub; lane_en = en;
      output_rdy_in = 1'b0;
      req_valid = 1'b1;
      check("accept_req_ready", req_ready, 1);
      cyc(); lat = 1;
      req_valid = 1'b0;
      op_a = ~a; op_b = ~b; op_c = ~c; op_d = ~d; sub_op = ~sub; lane_en = ~en;
      for (int k = 0; k < WIDTH; k++) begin
         w4 = {w4[14:0], serial4_out};
         w3 = {w3[14:0], serial3_out};
         w2 = {w2[14:0], serial2_out};
         w1 = {w1[14:0], serial1_out};
         su = {su[14:0], setup_serial_out};
         if (wr_out !== 1'b1) wr_bad++;
         cyc(); lat++;
      end
      while (result_valid !== 1'b1 && lat < 300) begin
         if (wr_out !== 1'b0) wr_bad++;
         if (output_read_out === 1'b1) rd_cnt++;
         if (rdy_at >= 0 && lat - WIDTH - 1 >= rdy_at) output_rdy_in = 1'b1;
         cyc(); lat++;
      end
      output_rdy_in = 1'b0;
      check("done_reached", result_valid, 1);
   endtask

   task automatic finish_txn();
      result_ready = 1'b1;
      check("hs_no_accept", req_ready, 0);
      cyc();
      result_ready = 1'b0;
      check("hs_idle_busy", busy, 0);
      check("hs_idle_req_ready", req_ready, 1);
      check("hs_idle_valid", result_valid, 0);
   endtask

   initial begin : main
      int lat, wrb, rdc, bad, n, accepts, wr_total;
      logic [15:0] w4, w3, w2, w1, su;

      rst_in = 1'b1; req_valid = 1'b0; result_ready = 1'b0; output_rdy_in = 1'b0;
      op_a = '0; op_b = '0; op_c = '0; op_d = '0; sub_op = '0; lane_en = '0;
      repeat (3) cyc();
      rst_in = 1'b0;
      cyc();
      check("rst_busy", busy, 0);
      check("rst_req_ready", req_ready, 1);
      check("rst_valid", result_valid, 0);
      check("rst_wr", wr_out, 0);
      check("rst_data", result_data, 0);
      check("rst_err", result_err, 0);

      // Basic add on lanes 4 and 3
      model_res = 16'h4200;
      do_txn(16'h3C00, 16'h4000, 16'h0000, 16'h0000, 3'd0, 4'b1100, 0, lat, w4, w3, w2, w1, su, wrb, rdc);
      check("add_lane4", w4, 16'h3C00);
      check("add_lane3", w3, 16'h4000);
      check("add_lane2", w2, 16'h0000);
      check("add_lane1", w1, 16'h0000);
      check("add_setup", su, 16'h0018);
      check("add_latency", lat, 35);
      check("add_strobes", wrb, 0);
      check("add_reads", rdc, 16);
      check("add_data", result_data, 16'h4200);
      check("add_err", result_err, 0);
      finish_txn();

      // Timeout: adder never ready
      model_res = 16'hFFFF;
      do_txn(16'h1111, 16'h2222, 16'h3333, 16'h4444, 3'd1, 4'b1111, -1, lat, w4, w3, w2, w1, su, wrb, rdc);
      check("tmo_latency", lat, 81);
      check("tmo_err", result_err, 1);
      check("tmo_data", result_data, 0);
      check("tmo_reads", rdc, 0);
      check("tmo_setup", su, 16'h003E);
      finish_txn();

      // Backpressure: consumer stalls 10 cycles
      model_res = 16'hBEEF;
      do_txn(16'hABCD, 16'h0000, 16'h0000, 16'h0000, 3'd0, 4'b1000, 2, lat, w4, w3, w2, w1, su, wrb, rdc);
      check("bp_latency", lat, 37);
      check("bp_lane4", w4, 16'hABCD);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (result_data !== 16'hBEEF || req_ready !== 1'b0 || result_valid !== 1'b1 || wr_out !== 1'b0) bad++;
         cyc();
      end
      check("bp_stall_stable", bad, 0);
      check("bp_data", result_data, 16'hBEEF);
      finish_txn();

      // Reset during LOAD cycle 7
      op_a = 16'hFFFF; op_b = 16'hFFFF; op_c = 16'hFFFF; op_d = 16'hFFFF; lane_en = 4'hF; sub_op = 3'd7;
      req_valid = 1'b1;
      cyc();
      req_valid = 1'b0;
      repeat (7) cyc();
      check("rl_in_load", wr_out, 1);
      rst_in = 1'b1;
      cyc();
      rst_in = 1'b0;
      check("rl_wr", wr_out, 0);
      check("rl_serial", {serial4_out, serial3_out, serial2_out, serial1_out, setup_serial_out}, 0);
      check("rl_busy", busy, 0);
      check("rl_req_ready", req_ready, 1);
      check("rl_valid", result_valid, 0);
      check("rl_data", result_data, 0);
      model_res = 16'h1234;
      do_txn(16'h8001, 16'h00FF, 16'hF00F, 16'h5A5A, 3'd2, 4'b1111, 0, lat, w4, w3, w2, w1, su, wrb, rdc);
      check("rl2_lane4", w4, 16'h8001);
      check("rl2_lane3", w3, 16'h00FF);
      check("rl2_lane2", w2, 16'hF00F);
      check("rl2_lane1", w1, 16'h5A5A);
      check("rl2_setup", su, 16'h005E);
      check("rl2_latency", lat, 35);
      check("rl2_data", result_data, 16'h1234);
      finish_txn();

      // All lanes disabled still runs the full sequence
      model_res = 16'h0F0F;
      do_txn(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 3'd5, 4'b0000, 0, lat, w4, w3, w2, w1, su, wrb, rdc);
      check("dis_lanes", {w4 | w3 | w2 | w1}, 0);
      check("dis_setup", su, 16'h00A0);
      check("dis_latency", lat, 35);
      check("dis_strobes", wrb, 0);
      check("dis_data", result_data, 16'h0F0F);
      finish_txn();

      // Back-to-back: second request held during the first transaction
      model_res = 16'hC3A5;
      op_a = 16'h0000; op_b = 16'h0000; op_c = 16'h8421; op_d = 16'h0001; lane_en = 4'b0011; sub_op = 3'd0;
      output_rdy_in = 1'b1;
      req_valid = 1'b1;
      n = 0; accepts = 0; wr_total = 0;
      while (result_valid !== 1'b1 && n < 300) begin
         if (req_valid === 1'b1 && req_ready === 1'b1) accepts++;
         if (wr_out === 1'b1) wr_total++;
         cyc(); n++;
      end
      check("b2b_latency", n, 35);
      check("b2b_accepts", accepts, 1);
      check("b2b_wr_count", wr_total, 16);
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         if (wr_out !== 1'b0 || req_ready !== 1'b0) bad++;
         cyc();
      end
      check("b2b_done_quiet", bad, 0);
      result_ready = 1'b1;
      check("b2b_hs_no_accept", req_ready, 0);
      check("b2b_data1", result_data, 16'hC3A5);
      cyc();
      result_ready = 1'b0;
      check("b2b_idle_req_ready", req_ready, 1);
      check("b2b_idle_busy", busy, 0);
      cyc();
      req_valid = 1'b0;
      check("b2b_second_busy", busy, 1);
      check("b2b_second_wr", wr_out, 1);
      model_res = 16'h5A5A;
      n = 1;
      while (result_valid !== 1'b1 && n < 300) begin
         cyc(); n++;
      end
      check("b2b_latency2", n, 35);
      check("b2b_data2", result_data, 16'h5A5A);
      output_rdy_in = 1'b0;
      finish_txn();

      // Ready arrives on the very last WAIT cycle
      model_res = 16'h7E57;
      do_txn(16'h0001, 16'h0002, 16'h0003, 16'h0004, 3'd3, 4'b0101, 63, lat, w4, w3, w2, w1, su, wrb, rdc);
      check("edge_latency", lat, 98);
      check("edge_err", result_err, 0);
      check("edge_data", result_data, 16'h7E57);
      check("edge_reads", rdc, 16);
      check("edge_lane3", w3, 16'h0002);
      check("edge_lane4", w4, 16'h0000);
      finish_txn();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fp_adder_sequencer.md
FP_ADDER_SEQUENCER -- requirements
Module: fp_adder_sequencer

Interface
REQ-001 Parameters, one per line, as name, default, meaning:
- WIDTH, 16, operand and result width in bits.
- TIMEOUT, 64, maximum WAIT cycles before the transaction aborts.
- READ_LAT, 1, cycles from the first output_read_out to the first valid serial_in bit.

REQ-002 Ports, one per line, as name, direction, width, meaning:
- clk_in, in, 1, sole clock; all logic on rising edge.
- rst_in, in, 1, synchronous active-high reset.
- req_valid, in, 1, request present.
- req_ready, out, 1, sequencer can accept a request.
- op_a / op_b / op_c / op_d, in, WIDTH each, operands driven onto lanes 4 / 3 / 2 / 1.
- sub_op, in, 3, add/sub control word for the adder.
- lane_en, in, 4, lane enables; bit i enables lane i+1.
- serial1_out..serial4_out, out, 1 each, lane serial data to the adder.
- setup_serial_out, out, 1, setup register serial data.
- wr_out, out, 1, adder write/shift strobe.
- output_rdy_in, in, 1, adder result available.
- output_read_out, out, 1, adder result read strobe.
- serial_in, in, 1, adder serial result.
- result_valid, out, 1, result held for the consumer.
- result_ready, in, 1, consumer accepts the result.
- result_data, out, WIDTH, assembled result.
- result_err, out, 1, transaction timed out.
- busy, out, 1, state is not IDLE.

Function
REQ-003 FSM states SHALL be IDLE, LOAD, WAIT, READ, DONE; busy = (state != IDLE).
REQ-004 req_ready SHALL be 1 only in IDLE.
REQ-005 On req_valid & req_ready, the block SHALL:
- capture all operands, sub_op and lane_en;
- clear result_err;
- enter LOAD next cycle.
REQ-006 LOAD SHALL last exactly WIDTH cycles with wr_out=1; cycle k (0..WIDTH-1) drives bit WIDTH-1-k of each captured operand (MSB first).
REQ-007 A lane with lane_en bit clear SHALL drive 0 on its serial output for the whole LOAD.
REQ-008 Setup word SHALL be {sub_op, lane_en[3], lane_en[2], lane_en[1], lane_en[0], 1'b0}; bit 0 = 0 selects the internal clock.
REQ-009 setup_serial_out SHALL be 0 during LOAD cycles 0..WIDTH-9 and bit WIDTH-1-k of the setup word (MSB first) during cycles WIDTH-8..WIDTH-1, so the last 8 bits shifted form the setup word.
REQ-010 Outside LOAD, wr_out, setup_serial_out and all serialN_out SHALL be 0.
REQ-011 WAIT SHALL count cycles from 0.
- output_rdy_in=1 -> go to READ next cycle.
- Count reaches TIMEOUT-1 with output_rdy_in=0 -> go to DONE with result_err=1 and result_data=0.
- If output_rdy_in=1 on the timeout cycle, READ takes priority.
REQ-012 READ SHALL last WIDTH+READ_LAT cycles.
- output_read_out=1 for the first WIDTH cycles, 0 thereafter.
- At READ cycle j >= READ_LAT, serial_in SHALL be shifted into result_data LSB-side, so the first captured bit lands in result_data[WIDTH-1] (MSB first).
REQ-013 On READ exit, the block SHALL enter DONE with result_valid=1.
REQ-014 In DONE, result_data and result_err SHALL hold stable while result_valid=1.
REQ-015 result_valid & result_ready SHALL return the block to IDLE next cycle with result_valid=0; req_ready rises that same cycle.
REQ-016 No new request SHALL be accepted in the cycle result_valid & result_ready is seen.
REQ-017 Minimum latency from acceptance to result_valid SHALL be:
- 1 cycle (to enter LOAD);
- + WIDTH cycles of LOAD;
- + 1 cycle of WAIT when output_rdy_in is already high;
- + WIDTH+READ_LAT cycles of READ;
- = 2*WIDTH+READ_LAT+2 cycles; 35 with defaults.
REQ-018 Bit counter SHALL be 5 bits; timeout counter SHALL be ceil(log2(TIMEOUT)) bits; neither SHALL wrap inside a state.
REQ-019 lane_en=0 SHALL still run the full sequence, with all lanes driving zeros.
REQ-020 Input changes on op_*, sub_op and lane_en after acceptance SHALL have no effect on the current transaction.

Reset
REQ-021 rst_in=1 at a rising edge SHALL force the following, regardless of state:
- state IDLE, counters 0;
- result_data=0, result_err=0, result_valid=0;
- wr_out=0, output_read_out=0, setup_serial_out=0, serialN_out=0;
- busy=0, req_ready=1 (effective the cycle after).
REQ-022 Reset asserted mid-LOAD or mid-READ SHALL abort the transaction with no further strobes, and no partial result shall be presented.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Basic add: op_a=16'h3C00, op_b=16'h4000, op_c=op_d=0, lane_en=4'b1100, sub_op=0; adder model returns 16'h4200 with output_rdy_in at WAIT cycle 0. Required: serial4/serial3 streams equal op_a/op_b MSB first, serial1/serial2 stay 0, last 8 setup bits = 8'b000_1100_0, result_valid 35 cycles after acceptance, result_data=16'h4200, result_err=0.
- Timeout: output_rdy_in held 0. Required: DONE after 64 WAIT cycles, result_err=1, result_data=0, output_read_out never asserted.
- Backpressure: result_ready=0 for 10 cycles in DONE. Required: result_data stable, req_ready=0 throughout; IDLE the cycle after the handshake.
- Reset mid-LOAD at LOAD cycle 7. Required: wr_out=0 on the next cycle, then busy=0 and req_ready=1, and a following request completes normally.
- Back-to-back: second req_valid held high through the first transaction. Required: accepted only in the cycle after the first result handshake; wr_out never asserted in READ or DONE.
- Boundary: output_rdy_in rises exactly at WAIT cycle 63. Required: READ is entered, result_err=0.
